// File: rtl/multi_ce_gen.sv
// ---------------------------------------------------------------------------
// multi_ce_gen
//   NCH independent fractional clock-enable generators. Each channel adds its
//   rate to a modulo-CLK_HZ phase accumulator every enabled cycle and emits a
//   one-cycle ce pulse on every wrap. Over any whole second the pulse count
//   therefore equals the rate, with no drift.
//   In auto mode a channel measures its own pulse count between rising sync
//   edges, scales it by 60, and clamps the result to [RATE_MIN, CLK_HZ]. From
//   then on the measured rate drives the accumulator instead of rate_in.
//
// Parameters
//   NCH       number of channels (1..8)
//   ACC_W     width of rate, accumulator and measurement words
//   CLK_HZ    clk_sys frequency; accumulator modulus and upper rate clamp
//   RATE_MIN  lower clamp for measured rates
//
// Ports
//   clk_sys   in   1          sole clock, rising edge
//   reset_n   in   1          asynchronous active-low reset
//   en        in   NCH        per-channel run enable
//   auto      in   NCH        0: rate_in drives channel, 1: measured rate
//   rate_in   in   NCH*ACC_W  target rate in Hz, channel k at [k*ACC_W +: ACC_W]
//   sync      in   NCH        frame sync (clk_sys domain), rising edge used
//   ce        out  NCH        one-cycle clock-enable pulses
//   rate_cur  out  NCH*ACC_W  rate currently applied to each accumulator
//   meas_vld  out  NCH        a measured rate is held for that channel
// ---------------------------------------------------------------------------
module multi_ce_gen #(
  parameter int NCH      = 2,
  parameter int ACC_W    = 32,
  parameter int CLK_HZ   = 42000000,
  parameter int RATE_MIN = 5000000
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic [NCH-1:0]       en,
  input  logic [NCH-1:0]       auto,
  input  logic [NCH*ACC_W-1:0] rate_in,
  input  logic [NCH-1:0]       sync,
  output logic [NCH-1:0]       ce,
  output logic [NCH*ACC_W-1:0] rate_cur,
  output logic [NCH-1:0]       meas_vld
);

  localparam logic [ACC_W-1:0]   LP_MOD   = ACC_W'(CLK_HZ);
  localparam logic [ACC_W-1:0]   LP_MIN   = ACC_W'(RATE_MIN);
  localparam logic [2*ACC_W-1:0] LP_MOD_W = (2*ACC_W)'(CLK_HZ);
  localparam logic [2*ACC_W-1:0] LP_MIN_W = (2*ACC_W)'(RATE_MIN);

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [ACC_W-1:0]   w_rate_in;
    logic [ACC_W-1:0]   w_src;
    logic [ACC_W-1:0]   w_sel;
    logic [ACC_W:0]     w_nxt;
    logic [ACC_W-1:0]   w_cnt_inc;
    logic [2*ACC_W-1:0] w_cnt_w;
    logic [2*ACC_W-1:0] w_prod;
    logic [ACC_W-1:0]   w_meas;
    logic               w_sync_rise;

    logic [ACC_W-1:0]   r_sel;
    logic [ACC_W-1:0]   r_rate;
    logic [ACC_W-1:0]   r_sum;
    logic               r_ce;
    logic [ACC_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_meas;
    logic               r_vld;
    logic               r_sync_q;
    logic               r_auto_q;
    logic               r_started;

    assign w_rate_in = rate_in[k*ACC_W +: ACC_W];

    // Measured rate is only used once one has actually been captured.
    assign w_src = (auto[k] && r_vld) ? r_meas : w_rate_in;
    assign w_sel = (w_src > LP_MOD) ? LP_MOD : w_src;

    // sum < CLK_HZ and rate <= CLK_HZ, so one extra bit holds the sum and a
    // single subtraction always brings it back into range.
    assign w_nxt = {1'b0, r_sum} + {1'b0, r_rate};

    // count*60 as a shift-add, at double width so a large count clamps
    // instead of wrapping.
    assign w_cnt_w = {{ACC_W{1'b0}}, r_cnt};
    assign w_prod  = (w_cnt_w << 5) + (w_cnt_w << 4) + (w_cnt_w << 3) + (w_cnt_w << 2);
    assign w_meas  = (w_prod > LP_MOD_W) ? LP_MOD :
                     (w_prod < LP_MIN_W) ? LP_MIN : ACC_W'(w_prod);

    assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + ACC_W'(r_ce);
    assign w_sync_rise = sync[k] & ~r_sync_q;

    // Two-stage rate pipeline: select/clamp, then apply.
    // NOTE: every register here, the measurement word included, has an async
    // reset value so a reset mid-operation leaves no stale rate behind.
    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        r_sel  <= '0;
        r_rate <= '0;
      end else begin
        // NOTE: sequential state is written with <= only, so every register
        // samples the pre-edge values of its neighbours.
        r_sel  <= w_sel;
        r_rate <= r_sel;
      end
    end

    // Phase accumulator and registered ce.
    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        r_sum <= '0;
        r_ce  <= 1'b0;
      end else if (!en[k]) begin
        r_sum <= '0;
        r_ce  <= 1'b0;
      end else if (w_nxt >= {1'b0, LP_MOD}) begin
        r_sum <= ACC_W'(w_nxt - {1'b0, LP_MOD});
        r_ce  <= 1'b1;
      end else begin
        r_sum <= ACC_W'(w_nxt);
        r_ce  <= 1'b0;
      end
    end

    // Sync-interval pulse counting and measurement capture.
    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt     <= '0;
        r_meas    <= '0;
        r_vld     <= 1'b0;
        r_sync_q  <= 1'b0;
        r_auto_q  <= 1'b0;
        r_started <= 1'b0;
      end else begin
        // Edge detector keeps tracking sync in every mode.
        r_sync_q <= sync[k];
        r_auto_q <= auto[k];
        if (!en[k]) begin
          r_cnt     <= '0;
          r_vld     <= 1'b0;
          r_started <= 1'b0;
        end else if (!auto[k]) begin
          r_vld     <= 1'b0;
          r_started <= 1'b0;
        end else if (!r_auto_q) begin
          // Entry into auto mode: discard whatever was counted before.
          r_cnt     <= '0;
          r_started <= 1'b0;
        end else if (w_sync_rise) begin
          // The pulse landing in the edge cycle belongs to the new interval.
          r_cnt     <= ACC_W'(r_ce);
          r_started <= 1'b1;
          if (r_started) begin
            r_meas <= w_meas;
            r_vld  <= 1'b1;
          end
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end
    end

    assign ce[k]                     = r_ce;
    assign meas_vld[k]               = r_vld;
    assign rate_cur[k*ACC_W +: ACC_W] = r_rate;
  end

endmodule

// File: tb/tb_multi_ce_gen.sv
// ---------------------------------------------------------------------------
// tb_multi_ce_gen
//   Directed bench for multi_ce_gen. Two instances:
//     u_big   : default parameters (CLK_HZ=42 MHz, ACC_W=32), one channel,
//               for full-rate, clamp and 4-of-21 pattern checks.
//     u_small : CLK_HZ=1000, RATE_MIN=10, ACC_W=12, two channels, for the
//               auto-measurement, saturation, independence and reset cases.
// ---------------------------------------------------------------------------
module tb_multi_ce_gen;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic reset_n;

  // small instance
  logic [1:0]  s_en, s_auto, s_sync, s_ce, s_vld;
  logic [23:0] s_rate, s_rate_cur;

  // big instance
  logic        b_en, b_auto, b_sync, b_ce, b_vld;
  logic [31:0] b_rate, b_rate_cur;

  int n_tests = 0;
  int n_fail  = 0;

  multi_ce_gen #(
    .NCH(1), .ACC_W(32), .CLK_HZ(42000000), .RATE_MIN(5000000)
  ) u_big (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .en      (b_en),
    .auto    (b_auto),
    .rate_in (b_rate),
    .sync    (b_sync),
    .ce      (b_ce),
    .rate_cur(b_rate_cur),
    .meas_vld(b_vld)
  );

  multi_ce_gen #(
    .NCH(2), .ACC_W(12), .CLK_HZ(1000), .RATE_MIN(10)
  ) u_small (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .en      (s_en),
    .auto    (s_auto),
    .rate_in (s_rate),
    .sync    (s_sync),
    .ce      (s_ce),
    .rate_cur(s_rate_cur),
    .meas_vld(s_vld)
  );

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic sync_pulse(input int ch);
    s_sync[ch] = 1'b1;
    step(1);
    s_sync[ch] = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    s_en = 2'b01; s_auto = 2'b00; s_sync = 2'b00; s_rate = {12'd0, 12'd250};
    b_en = 1'b1;  b_auto = 1'b0;  b_sync = 1'b0;  b_rate = 32'd42000000;
    step(2);
    n_tests++;
    if (s_ce !== 2'b00 || s_vld !== 2'b00 || s_rate_cur !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_small: ce=%b vld=%b rate_cur=%h expected all 0", s_ce, s_vld, s_rate_cur);
    end
    n_tests++;
    if (b_ce !== 1'b0 || b_rate_cur !== 32'd0 || b_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_big: ce=%b rate_cur=%0d vld=%b expected 0", b_ce, b_rate_cur, b_vld);
    end
    reset_n = 1'b1;
    step(1);
    n_tests++;
    if (b_ce !== 1'b0 || b_rate_cur !== 32'd0) begin
      n_fail++;
      $display("FAIL release_c1: ce=%b rate_cur=%0d expected 0/0", b_ce, b_rate_cur);
    end
    step(1);
    n_tests++;
    if (b_ce !== 1'b0 || b_rate_cur !== 32'd42000000) begin
      n_fail++;
      $display("FAIL release_c2: ce=%b rate_cur=%0d expected 0/42000000", b_ce, b_rate_cur);
    end
    step(1);
    n_tests++;
    if (b_ce !== 1'b1) begin
      n_fail++;
      $display("FAIL release_c3: ce=%b expected 1", b_ce);
    end
  endtask

  task automatic test_full_rate_clamp;
    for (int i = 0; i < 8; i++) begin
      step(1);
      n_tests++;
      if (b_ce !== 1'b1 || b_rate_cur !== 32'd42000000) begin
        n_fail++;
        $display("FAIL full_rate[%0d]: ce=%b rate_cur=%0d expected 1/42000000", i, b_ce, b_rate_cur);
      end
    end
    b_rate = 32'd50000000;
    for (int i = 0; i < 10; i++) begin
      step(1);
      n_tests++;
      if (b_ce !== 1'b1 || b_rate_cur !== 32'd42000000) begin
        n_fail++;
        $display("FAIL clamp_rate[%0d]: ce=%b rate_cur=%0d expected 1/42000000", i, b_ce, b_rate_cur);
      end
    end
  endtask

  task automatic test_fixed_pattern;
    // Pulses on cycles 6, 11, 16, 21 of each 21-cycle period (bit i = cycle i+1).
    logic [20:0] pat;
    int          cnt;
    pat = 21'b100001000010000100000;
    cnt = 0;
    b_rate = 32'd8000000;
    step(3);
    b_en = 1'b0;
    step(1);
    n_tests++;
    if (b_ce !== 1'b0) begin
      n_fail++;
      $display("FAIL en_off_ce: ce=%b expected 0", b_ce);
    end
    b_en = 1'b1;
    for (int k = 0; k < 42; k++) begin
      step(1);
      if (k < 21 && b_ce === 1'b1) cnt++;
      n_tests++;
      if (b_ce !== pat[k % 21]) begin
        n_fail++;
        $display("FAIL pattern_21[%0d]: ce=%b expected %b", k + 1, b_ce, pat[k % 21]);
      end
    end
    n_tests++;
    if (cnt != 4) begin
      n_fail++;
      $display("FAIL pulses_per_21: got %0d expected 4", cnt);
    end
  endtask

  task automatic test_auto_measure;
    int cnt;
    cnt = 0;
    s_auto = 2'b01;
    step(3);
    sync_pulse(0);
    n_tests++;
    if (s_vld[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL first_edge_vld: vld=%b expected 0", s_vld[0]);
    end
    step(39);
    sync_pulse(0);
    n_tests++;
    if (s_vld[0] !== 1'b1 || s_rate_cur[11:0] !== 12'd250) begin
      n_fail++;
      $display("FAIL meas40_vld: vld=%b rate_cur=%0d expected 1/250", s_vld[0], s_rate_cur[11:0]);
    end
    step(1);
    n_tests++;
    if (s_rate_cur[11:0] !== 12'd250) begin
      n_fail++;
      $display("FAIL meas40_lat1: rate_cur=%0d expected 250", s_rate_cur[11:0]);
    end
    step(1);
    n_tests++;
    if (s_rate_cur[11:0] !== 12'd600) begin
      n_fail++;
      $display("FAIL meas40_rate: rate_cur=%0d expected 600", s_rate_cur[11:0]);
    end
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (s_ce[0] === 1'b1) cnt++;
    end
    n_tests++;
    if (cnt != 18) begin
      n_fail++;
      $display("FAIL rate600_pulses: got %0d in 30 cycles expected 18", cnt);
    end
  endtask

  task automatic test_meas_short;
    s_auto[0] = 1'b0;
    s_rate[11:0] = 12'd1000;
    step(4);
    n_tests++;
    if (s_vld[0] !== 1'b0 || s_rate_cur[11:0] !== 12'd1000) begin
      n_fail++;
      $display("FAIL auto_fall: vld=%b rate_cur=%0d expected 0/1000", s_vld[0], s_rate_cur[11:0]);
    end
    s_auto[0] = 1'b1;
    step(1);
    sync_pulse(0);
    step(1);
    sync_pulse(0);
    n_tests++;
    if (s_vld[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL meas2_vld: vld=%b expected 1", s_vld[0]);
    end
    step(2);
    n_tests++;
    if (s_rate_cur[11:0] !== 12'd120) begin
      n_fail++;
      $display("FAIL meas2_rate: rate_cur=%0d expected 120", s_rate_cur[11:0]);
    end
  endtask

  task automatic test_meas_zero;
    s_auto[0] = 1'b0;
    s_rate[11:0] = 12'd0;
    step(4);
    sync_pulse(0);
    step(1);
    n_tests++;
    if (s_vld[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL sync_ignored: vld=%b expected 0", s_vld[0]);
    end
    s_auto[0] = 1'b1;
    step(1);
    sync_pulse(0);
    for (int i = 0; i < 5; i++) begin
      step(1);
      n_tests++;
      if (s_ce[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL rate0_ce[%0d]: ce=%b expected 0", i, s_ce[0]);
      end
    end
    sync_pulse(0);
    n_tests++;
    if (s_vld[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL meas0_vld: vld=%b expected 1", s_vld[0]);
    end
    step(2);
    n_tests++;
    if (s_rate_cur[11:0] !== 12'd10) begin
      n_fail++;
      $display("FAIL meas0_rate: rate_cur=%0d expected 10", s_rate_cur[11:0]);
    end
  endtask

  task automatic test_meas_saturate;
    s_auto[0] = 1'b0;
    s_rate[11:0] = 12'd1000;
    step(4);
    s_auto[0] = 1'b1;
    step(1);
    sync_pulse(0);
    // 4100 pulses: a wrapping 12-bit counter would read 4 (meas 240).
    step(4099);
    sync_pulse(0);
    n_tests++;
    if (s_vld[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_vld: vld=%b expected 1", s_vld[0]);
    end
    step(2);
    n_tests++;
    if (s_rate_cur[11:0] !== 12'd1000) begin
      n_fail++;
      $display("FAIL sat_rate: rate_cur=%0d expected 1000", s_rate_cur[11:0]);
    end
  endtask

  task automatic test_independence;
    logic prev;
    s_auto = 2'b00;
    s_rate = {12'd100, 12'd500};
    s_en   = 2'b11;
    step(4);
    prev = s_ce[0];
    s_en[1] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(1);
      n_tests++;
      if (s_ce[1] !== 1'b0 || s_ce[0] !== ~prev) begin
        n_fail++;
        $display("FAIL ch1_off[%0d]: ce1=%b ce0=%b expected 0/%b", i, s_ce[1], s_ce[0], ~prev);
      end
      prev = s_ce[0];
    end
    s_en[1] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      n_tests++;
      if (s_ce[1] !== (k == 10) || s_ce[0] !== ~prev) begin
        n_fail++;
        $display("FAIL ch1_resume[%0d]: ce1=%b ce0=%b expected %b/%b", k, s_ce[1], s_ce[0], (k == 10), ~prev);
      end
      prev = s_ce[0];
    end
  endtask

  task automatic test_reset_mid;
    s_en = 2'b01;
    s_auto = 2'b01;
    s_rate = {12'd0, 12'd250};
    step(3);
    sync_pulse(0);
    step(39);
    sync_pulse(0);
    n_tests++;
    if (s_vld[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_en_vld: vld=%b expected 1", s_vld[0]);
    end
    s_en[0] = 1'b0;
    step(1);
    n_tests++;
    if (s_vld[0] !== 1'b0 || s_ce[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL en_clear: vld=%b ce=%b expected 0/0", s_vld[0], s_ce[0]);
    end
    s_en[0] = 1'b1;
    step(2);
    sync_pulse(0);
    step(10);
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (s_ce !== 2'b00 || s_vld !== 2'b00 || s_rate_cur !== 24'd0 ||
        b_ce !== 1'b0 || b_rate_cur !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset: s_ce=%b s_vld=%b s_rate=%h b_ce=%b b_rate=%0d expected all 0",
               s_ce, s_vld, s_rate_cur, b_ce, b_rate_cur);
    end
    step(2);
    reset_n = 1'b1;
    step(3);
    n_tests++;
    if (s_rate_cur[11:0] !== 12'd250 || s_vld[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_fixed: rate_cur=%0d vld=%b expected 250/0", s_rate_cur[11:0], s_vld[0]);
    end
    sync_pulse(0);
    n_tests++;
    if (s_vld[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_edge1: vld=%b expected 0", s_vld[0]);
    end
    step(39);
    n_tests++;
    if (s_vld[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_wait: vld=%b expected 0", s_vld[0]);
    end
    sync_pulse(0);
    n_tests++;
    if (s_vld[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_edge2: vld=%b expected 1", s_vld[0]);
    end
    step(2);
    n_tests++;
    if (s_rate_cur[11:0] !== 12'd600) begin
      n_fail++;
      $display("FAIL post_reset_rate: rate_cur=%0d expected 600", s_rate_cur[11:0]);
    end
  endtask

  initial begin
    test_reset();
    test_full_rate_clamp();
    test_fixed_pattern();
    test_auto_measure();
    test_meas_short();
    test_meas_zero();
    test_meas_saturate();
    test_independence();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
